// File: rtl/bcd_sub_4d_seq.sv
// Digit-serial 4-digit BCD subtractor producing |A - B| plus a sign flag.
// Negative raw differences get a second serial pass to form 10000 - R.
module bcd_sub_4d_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A3,
  input  logic [3:0] A2,
  input  logic [3:0] A1,
  input  logic [3:0] A0,
  input  logic [3:0] B3,
  input  logic [3:0] B2,
  input  logic [3:0] B1,
  input  logic [3:0] B0,
  output logic       busy,
  output logic       done,
  output logic [3:0] D3,
  output logic [3:0] D2,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       NEG,
  output logic       ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [3:0][3:0] a_in, b_in;
  logic [3:0][3:0] a_reg, a_next;
  logic [3:0][3:0] b_reg, b_next;
  logic [3:0][3:0] r_reg, r_next;
  logic [3:0][3:0] d_reg, d_next;
  logic [1:0]      idx_reg, idx_next;
  logic            borrow_reg, borrow_next;
  logic            neg_reg, neg_next;
  logic            err_reg, err_next;

  logic [3:0] digit_bad;
  logic       in_bad;

  assign a_in = {A3, A2, A1, A0};
  assign b_in = {B3, B2, B1, B0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chk
      assign digit_bad[gi] = (a_in[gi] > 4'd9) || (b_in[gi] > 4'd9);
    end
  endgenerate
  assign in_bad = |digit_bad;

  // Shared digit step: SUB uses A/B digits, NEG subtracts the raw result from 0.
  logic [3:0] step_x, step_y, step_digit;
  logic [4:0] step_t;
  logic       step_borrow;

  always_comb begin
    step_x      = (state_reg == S_SUB) ? a_reg[idx_reg] : 4'd0;
    step_y      = (state_reg == S_SUB) ? b_reg[idx_reg] : r_reg[idx_reg];
    step_t      = {1'b0, step_x} - {1'b0, step_y} - {4'd0, borrow_reg};
    step_borrow = step_t[4];
    step_digit  = step_t[4] ? (step_t[3:0] + 4'd10) : step_t[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      r_reg      <= '0;
      d_reg      <= '0;
      idx_reg    <= 2'd0;
      borrow_reg <= 1'b0;
      neg_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      r_reg      <= r_next;
      d_reg      <= d_next;
      idx_reg    <= idx_next;
      borrow_reg <= borrow_next;
      neg_reg    <= neg_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    r_next      = r_reg;
    d_next      = d_reg;
    idx_next    = idx_reg;
    borrow_next = borrow_reg;
    neg_next    = neg_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_next = a_in;
          b_next = b_in;
          if (in_bad) begin
            state_next = S_DONE;
            d_next     = '0;
            neg_next   = 1'b0;
            err_next   = 1'b1;
          end else begin
            state_next  = S_SUB;
            idx_next    = 2'd0;
            borrow_next = 1'b0;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SUB: begin
        r_next[idx_reg] = step_digit;
        idx_next        = idx_reg + 2'd1;
        borrow_next     = step_borrow;
        if (idx_reg == 2'd3) begin
          if (step_borrow) begin
            // A < B: r holds 10000 + A - B; restart the digit walk for the magnitude.
            state_next  = S_NEG;
            borrow_next = 1'b0;
          end else begin
            state_next = S_DONE;
            d_next     = r_next;
            neg_next   = 1'b0;
            err_next   = 1'b0;
          end
        end
      end
      S_NEG: begin
        r_next[idx_reg] = step_digit;
        idx_next        = idx_reg + 2'd1;
        borrow_next     = step_borrow;
        if (idx_reg == 2'd3) begin
          state_next = S_DONE;
          d_next     = r_next;
          neg_next   = 1'b1;
          err_next   = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == S_SUB) || (state_reg == S_NEG);
    done = (state_reg == S_DONE);
  end

  assign D3  = d_reg[3];
  assign D2  = d_reg[2];
  assign D1  = d_reg[1];
  assign D0  = d_reg[0];
  assign NEG = neg_reg;
  assign ERR = err_reg;

endmodule

// File: tb/tb_bcd_sub_4d_seq.sv
// Bench for bcd_sub_4d_seq: vector table plus handshake, chaining and reset sequences,
// with expected results queued at issue time and checked on each done pulse.
module tb_bcd_sub_4d_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_drv, b_drv;
  logic        busy, done, NEG, ERR;
  logic [3:0]  D3, D2, D1, D0;
  logic [15:0] d_out;

  assign d_out = {D3, D2, D1, D0};

  bcd_sub_4d_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .A3(a_drv[15:12]), .A2(a_drv[11:8]), .A1(a_drv[7:4]), .A0(a_drv[3:0]),
    .B3(b_drv[15:12]), .B2(b_drv[11:8]), .B1(b_drv[7:4]), .B0(b_drv[3:0]),
    .busy(busy), .done(done),
    .D3(D3), .D2(D2), .D1(D1), .D0(D0),
    .NEG(NEG), .ERR(ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        neg;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input vec_t v);
    a_drv = v.a;
    b_drv = v.b;
    start = 1'b1;
    sb.push_back(v);
  endtask

  // Call just after issue(); walks cycles 1.. after the sampling edge.
  task automatic wait_result(input bit chain, input vec_t nv, input bit repulse);
    vec_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    e    = sb[0];
    lat  = e.lat;
    @(posedge clk);
    for (int k = 1; k <= lat + 3 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (repulse && k == 2) begin
        a_drv = 16'h0012;
        b_drv = 16'h0045;
        start = 1'b1;
      end
      chk("busy", {31'd0, busy}, {31'd0, (k < lat)});
      chk("done", {31'd0, done}, {31'd0, (k == lat)});
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("D", {16'd0, d_out}, {16'd0, e.d});
        chk("NEG", {31'd0, NEG}, {31'd0, e.neg});
        chk("ERR", {31'd0, ERR}, {31'd0, e.err});
        $display("txn %h - %h -> D=%h NEG=%0b ERR=%0b cycle=%0d", e.a, e.b, d_out, NEG, ERR, k);
        if (chain) issue(nv);
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: no done, got none expected cycle %0d", lat);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t none;
    bit   saw_done;
    none = '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 5};

    vecs[0]  = '{16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 5};
    vecs[1]  = '{16'h0012, 16'h0045, 16'h0033, 1'b1, 1'b0, 9};
    vecs[2]  = '{16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5};
    vecs[3]  = '{16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 9};
    vecs[4]  = '{16'h7777, 16'h7777, 16'h0000, 1'b0, 1'b0, 5};
    vecs[5]  = '{16'h12A4, 16'h0003, 16'h0000, 1'b0, 1'b1, 1};
    vecs[6]  = '{16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 5};
    vecs[7]  = '{16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 5};
    vecs[8]  = '{16'h5000, 16'h5001, 16'h0001, 1'b1, 1'b0, 9};
    vecs[9]  = '{16'h0500, 16'h0499, 16'h0001, 1'b0, 1'b0, 5};
    vecs[10] = '{16'h1234, 16'h000F, 16'h0000, 1'b0, 1'b1, 1};
    vecs[11] = '{16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 9};

    rst   = 1'b1;
    start = 1'b0;
    a_drv = '0;
    b_drv = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_D", {16'd0, d_out}, 32'd0);
    chk("rst_NEG", {31'd0, NEG}, 32'd0);
    chk("rst_ERR", {31'd0, ERR}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i]);
      wait_result(1'b0, none, 1'b0);
      @(negedge clk);
    end

    // start re-pulsed at cycle 2 must be ignored
    issue(vecs[0]);
    wait_result(1'b0, none, 1'b1);
    @(negedge clk);

    // start held in the done cycle with new operands
    issue('{16'h2000, 16'h0001, 16'h1999, 1'b0, 1'b0, 5});
    wait_result(1'b1, '{16'h0300, 16'h0100, 16'h0200, 1'b0, 1'b0, 5}, 1'b0);
    wait_result(1'b0, none, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_D", {16'd0, d_out}, 32'h0200);

    // asynchronous reset inside cycle 3 of a SUB pass
    a_drv = 16'h5432;
    b_drv = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_D", {16'd0, d_out}, 32'd0);
    chk("arst_NEG", {31'd0, NEG}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("arst_no_done", {31'd0, saw_done}, 32'd0);
    issue('{16'h0100, 16'h0001, 16'h0099, 1'b0, 1'b0, 5});
    wait_result(1'b0, none, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
